// File: rtl/apb_completer_regfile.sv
// APB3 completer fronting NUM_REGS control registers with wait states.
// Optional byte strobes: define APB_PSTRB_EN to add the pstrb port.
module apb_completer_regfile #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 8,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                       clk,
   input  logic                       preset,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [ADDR_W-1:0]          paddr,
   input  logic [DATA_W-1:0]          pwdata_in,
`ifdef APB_PSTRB_EN
   input  logic [DATA_W/8-1:0]        pstrb,
`endif
   output logic [DATA_W-1:0]          prdata_out,
   output logic                       pready,
   output logic                       pslverr,
   output logic [NUM_REGS*DATA_W-1:0] reg_q,
   output logic [NUM_REGS-1:0]        wr_pulse
);

   localparam int NB  = DATA_W / 8;
   localparam int LSB = $clog2(NB);
   localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W-1:0] LOW_M = ADDR_W'((1 << LSB) - 1);

   typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic                       wr_q, wr_d;
   logic                       err_q, err_d;
   logic [DATA_W-1:0]          wdata_q, wdata_d;
   logic [NB-1:0]              strb_q, strb_d, strb_in;
   logic [ADDR_W-1:0]          idx_full;
   logic                       dec_err, commit;
   logic                       pready_d, pslverr_d;
   logic [DATA_W-1:0]          prdata_d;
   logic [NUM_REGS*DATA_W-1:0] reg_d;
   logic [NUM_REGS-1:0]        wr_pulse_d;

`ifdef APB_PSTRB_EN
   assign strb_in = pstrb;
`else
   assign strb_in = '1;
`endif

   // Address decode: word index plus out-of-range / misaligned error.
   always_comb begin
      idx_full = paddr >> LSB;
      dec_err  = (32'(idx_full) >= 32'(NUM_REGS)) ||
                 (|(paddr & LOW_M));
   end

   // Transfer FSM: capture on setup, count wait states, one-cycle ready.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      err_d   = err_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               idx_d   = IW'(idx_full);
               wr_d    = pwrite;
               err_d   = dec_err;
               wdata_d = pwdata_in;
               strb_d  = strb_in;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES == 0) ? READY : WAIT;
            end
         end
         WAIT: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q <= 4'd1) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         READY: begin
            state_d = IDLE;
            commit  = psel && penable && pwrite && !err_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered response and register-bank next state.
   always_comb begin
      pready_d   = (state_d == READY);
      pslverr_d  = pready_d && err_d;
      prdata_d   = '0;
      reg_d      = reg_q;
      wr_pulse_d = '0;
      if (pready_d && !wr_d && !err_d) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_d == IW'(i)) prdata_d = reg_q[i*DATA_W +: DATA_W];
         end
      end
      if (commit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IW'(i)) begin
               wr_pulse_d[i] = 1'b1;
               for (int k = 0; k < NB; k++) begin
                  if (strb_q[k])
                     reg_d[i*DATA_W + k*8 +: 8] = wdata_q[k*8 +: 8];
               end
            end
         end
      end
   end

   // State, capture and output registers.
   always_ff @(posedge clk) begin
      if (preset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         wdata_q    <= '0;
         strb_q     <= '0;
         pready     <= 1'b0;
         pslverr    <= 1'b0;
         prdata_out <= '0;
         reg_q      <= '0;
         wr_pulse   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wr_q       <= wr_d;
         err_q      <= err_d;
         wdata_q    <= wdata_d;
         strb_q     <= strb_d;
         pready     <= pready_d;
         pslverr    <= pslverr_d;
         prdata_out <= prdata_d;
         reg_q      <= reg_d;
         wr_pulse   <= wr_pulse_d;
      end
   end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench for apb_completer_regfile: directed and random APB transfers
// checked against a register-array model with cycle-exact timing.
module tb_apb_completer_regfile;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int WC = 3;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          preset, psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata_in, prdata_out;
   logic          pready, pslverr;
   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0] wr_pulse;
`ifdef APB_PSTRB_EN
   logic [NB-1:0] pstrb;
`endif

   always #5 clk = ~clk;

   apb_completer_regfile #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk),
      .preset(preset),
      .psel(psel),
      .penable(penable),
      .pwrite(pwrite),
      .paddr(paddr),
      .pwdata_in(pwdata_in),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata_out(prdata_out),
      .pready(pready),
      .pslverr(pslverr),
      .reg_q(reg_q),
      .wr_pulse(wr_pulse)
   );

   int total = 0;
   int bad = 0;
   logic [DW-1:0] mdl [NR];
   logic          pend;
   logic [NR-1:0] exp_pulse;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR*DW-1:0] flat();
      logic [NR*DW-1:0] f;
      for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
      return f;
   endfunction

   task automatic post_chk();
      if (pend) begin
         chk("post_pready", 256'(pready), 256'(0));
         chk("wr_pulse", 256'(wr_pulse), 256'(exp_pulse));
         chk("reg_q", 256'(reg_q), 256'(flat()));
         pend = 1'b0;
      end
   endtask

   task automatic xfer(input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d, input logic [NB-1:0] s,
                       input bit b2b);
      logic err;
      int idx;
      logic [NB-1:0] se;
      idx = int'(a >> 2);
      err = (a[1:0] != 2'b00) || (idx >= NR);
`ifdef APB_PSTRB_EN
      se = s;
      pstrb = s;
`else
      se = '1;
`endif
      psel = 1'b1;
      penable = 1'b0;
      paddr = a;
      pwrite = w;
      pwdata_in = d;
      @(negedge clk);
      post_chk();
      @(posedge clk);
      #1 penable = 1'b1;
      for (int c = 1; c <= WC + 1; c++) begin
         @(negedge clk);
         chk("pready", 256'(pready), 256'(c == WC + 1));
         if (c == WC + 1) begin
            chk("pslverr", 256'(pslverr), 256'(err));
            if (!w)
               chk("prdata", 256'(prdata_out), 256'(err ? '0 : mdl[idx]));
         end else begin
            chk("pslverr_wait", 256'(pslverr), 256'(0));
            chk("prdata_wait", 256'(prdata_out), 256'(0));
         end
         if (c <= WC) @(posedge clk);
      end
      @(posedge clk);
      #1;
      exp_pulse = '0;
      if (w && !err) begin
         for (int k = 0; k < NB; k++)
            if (se[k]) mdl[idx][k*8 +: 8] = d[k*8 +: 8];
         exp_pulse[idx] = 1'b1;
      end
      pend = 1'b1;
      if (!b2b) begin
         psel = 1'b0;
         penable = 1'b0;
         @(negedge clk);
         post_chk();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      preset = 1'b1;
      psel = 1'b1;
      penable = 1'b0;
      pwrite = 1'b0;
      paddr = '0;
      pwdata_in = '0;
`ifdef APB_PSTRB_EN
      pstrb = '1;
`endif
      pend = 1'b0;
      exp_pulse = '0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pready", 256'(pready), 256'(0));
      chk("rst_pslverr", 256'(pslverr), 256'(0));
      chk("rst_prdata", 256'(prdata_out), 256'(0));
      chk("rst_reg_q", 256'(reg_q), 256'(0));
      chk("rst_wr_pulse", 256'(wr_pulse), 256'(0));
      @(posedge clk);
      #1 preset = 1'b0;
      psel = 1'b0;

      xfer(8'h0C, 1'b1, 32'h0000_00A5, '1, 1'b0);
      xfer(8'h0C, 1'b0, 32'h0, '1, 1'b0);
      xfer(8'h00, 1'b0, 32'h0, '1, 1'b0);
      xfer(8'h02, 1'b1, 32'hDEAD_BEEF, '1, 1'b0);
      xfer(8'h40, 1'b1, 32'hCAFE_F00D, '1, 1'b0);
      xfer(8'h41, 1'b0, 32'h0, '1, 1'b0);
      xfer(8'h1C, 1'b1, 32'h7777_8888, '1, 1'b0);
      xfer(8'h20, 1'b0, 32'h0, '1, 1'b0);

      xfer(8'h00, 1'b1, 32'h1122_3344, '1, 1'b0);
      xfer(8'h00, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0);
`ifdef APB_PSTRB_EN
      chk("strb_reg0", 256'(reg_q[31:0]), 256'(32'h11BB_33DD));
`endif
      xfer(8'h00, 1'b1, 32'h5555_5555, 4'b0000, 1'b0);
      xfer(8'h00, 1'b0, 32'h0, '1, 1'b0);

      xfer(8'h04, 1'b1, 32'h0BAD_CAFE, '1, 1'b1);
      xfer(8'h04, 1'b0, 32'h0, '1, 1'b1);
      xfer(8'h08, 1'b1, 32'h1234_5678, '1, 1'b1);
      xfer(8'h08, 1'b0, 32'h0, '1, 1'b0);

      repeat (40) begin
         xfer(AW'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
              $urandom, NB'($urandom), 1'($urandom_range(0, 1)));
      end
      psel = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      post_chk();
      @(posedge clk);
      #1;

      psel = 1'b1;
      penable = 1'b0;
      paddr = 8'h04;
      pwrite = 1'b1;
      pwdata_in = 32'h0000_005A;
      @(posedge clk);
      #1 penable = 1'b1;
      @(negedge clk);
      chk("abort_w1", 256'(pready), 256'(0));
      @(posedge clk);
      #1 psel = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      chk("abort_w2", 256'(pready), 256'(0));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_pready", 256'(pready), 256'(0));
         chk("abort_pulse", 256'(wr_pulse), 256'(0));
         chk("abort_reg_q", 256'(reg_q), 256'(flat()));
      end
      @(posedge clk);
      #1;

      psel = 1'b1;
      penable = 1'b0;
      paddr = 8'h08;
      pwrite = 1'b1;
      pwdata_in = 32'h0000_005A;
      @(posedge clk);
      #1 penable = 1'b1;
      @(posedge clk);
      #1 preset = 1'b1;
      @(posedge clk);
      #1 preset = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      @(negedge clk);
      chk("mrst_pready", 256'(pready), 256'(0));
      chk("mrst_pslverr", 256'(pslverr), 256'(0));
      chk("mrst_prdata", 256'(prdata_out), 256'(0));
      chk("mrst_reg_q", 256'(reg_q), 256'(0));
      chk("mrst_pulse", 256'(wr_pulse), 256'(0));
      for (int c = 0; c < WC + 3; c++) begin
         @(negedge clk);
         chk("penable_idle", 256'(pready), 256'(0));
         chk("penable_reg_q", 256'(reg_q), 256'(0));
      end
      @(posedge clk);
      #1 psel = 1'b0;
      penable = 1'b0;

      xfer(8'h10, 1'b1, 32'h600D_F00D, '1, 1'b0);
      xfer(8'h10, 1'b0, 32'h0, '1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
